matrix_multiplier: RTL and testbench
====================================

Name: matrix_multiplier

Overview:
- Output-stationary systolic array computing C = A x B.
- A is MxK, B is KxN, C is MxN, all unsigned integers.
- Core compute block of the AI accelerator: operand matrices arrive as flat buses, a start pulse launches one multiplication, and a done pulse marks C valid.
- Built from an MxN grid of multiply-accumulate PEs. A values flow right, B values flow down, with skewed injection.

Parameters:
- M, 4, rows of A and C
- N, 4, columns of B and C
- K, 4, inner dimension (columns of A, rows of B)
- DW, 16, operand element width
- AW, 32, accumulator and result element width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  launches one multiplication; sampled only while idle
- a_flat  in  M*K*DW  A[i][k] at bits (i*K+k)*DW +: DW
- b_flat  in  K*N*DW  B[k][j] at bits (k*N+j)*DW +: DW
- busy  out  1  high while a multiplication is in flight
- done  out  1  one-cycle pulse when c_flat updates
- c_flat  out  M*N*AW  C[i][j] at bits (i*N+j)*AW +: AW

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset: c_flat=0, done=0, busy=0, all PE accumulators and pipeline registers=0, state=IDLE.
- States: IDLE, RUN.
- IDLE -> RUN on a clock edge with start=1.
  - At that edge, a_flat and b_flat are captured into internal operand registers; later input changes do not affect the run.
  - Accumulators are cleared, step counter t=0, busy=1.
- RUN, step t (0..M+N+K-3):
  - Row i edge injection = A[i][t-i] when 0<=t-i<K, else 0.
  - Column j edge injection = B[t-j][j] when 0<=t-j<K, else 0.
  - Each PE forwards a right and b down through one register each.
  - PE(i,j) therefore multiplies A[i][k]*B[k][j] at step k+i+j.
- Arithmetic per PE:
  - acc <= acc + zero-extended DW x DW product.
  - Sum wraps modulo 2^AW; no saturation, no overflow flag.
- Completion:
  - done pulses exactly LAT = M+N+K-1 cycles after the start-capture edge; LAT = 11 for the defaults.
  - On that same edge, c_flat loads all accumulators, busy drops and the state returns to IDLE.
- c_flat holds its value until the next run completes or reset.
- start while busy=1 is ignored; no queuing.
- start held high: a new run begins on the first cycle after done.
- Reset mid-run aborts the run with no done pulse; c_flat returns to 0.

Optional Feature:
- Macro MATMUL_SIGNED_EN.
- Defined: operands are two's-complement. Products are sign-extended to AW before accumulation, and C is a two's-complement AW value (still wrapping).
- Undefined: unsigned, zero-extended arithmetic as above.
- Latency and interface are identical in both builds.

Decomposition:
- Package matmul_pkg:
  - default DW/AW constants
  - state enum type (IDLE, RUN)
  - LAT helper function of M,N,K
- One sub-module, matmul_pe:
  - registered a/b pass-through
  - clear input, enable input
  - AW-bit accumulator
  - MATMUL_SIGNED_EN handled inside
- Top level: generate grid, skew logic, step counter, FSM, output register.

Test Plan:
- Identity: A = 1..16 row-major, B = identity -> C equals A; C[0][0]=1, C[1][1]=6, C[2][2]=11, C[3][3]=16, C[0][1]=2, C[3][0]=13.
- All-ones A and B -> every C[i][j]=4. done exactly 11 cycles after the start edge; busy high for those 11 cycles.
- A,B all 0xFFFF (unsigned build) -> every C[i][j]=0xFFF80004 (wrap check). With MATMUL_SIGNED_EN -> every C[i][j]=4.
- Start pulse mid-run with different operands -> ignored. First result correct, exactly one done pulse.
- Change a_flat/b_flat during RUN -> result reflects captured operands only.
- Assert rst at cycle 5 of a run -> no done, c_flat=0, busy=0. A new start after reset produces the correct result.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, FSM state type and latency helper for the systolic matrix multiplier.
package matmul_pkg;

  localparam int DEF_DW = 16;
  localparam int DEF_AW = 32;

  typedef enum logic {IDLE, RUN} state_t;

  // Cycles from the start-capture edge to the done edge.
  function automatic int lat(input int m, input int n, input int k);
    return m + n + k - 1;
  endfunction

endpackage

// File: rtl/matmul_pe.sv
// Multiply-accumulate PE with registered a (right) / b (down) forwarding.
// MATMUL_SIGNED_EN selects two's-complement operands and sign-extended products.
module matmul_pe
  import matmul_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc
);

  logic [2*DW-1:0] prod;
  logic [AW-1:0]   prod_ext;

`ifdef MATMUL_SIGNED_EN
  // Low 2*DW bits of the extended product equal the signed product.
  assign prod     = {{DW{a_in[DW-1]}}, a_in} * {{DW{b_in[DW-1]}}, b_in};
  assign prod_ext = AW'($signed(prod));
`else
  assign prod     = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  assign prod_ext = AW'(prod);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (en) begin
      a_out <= a_in;
      b_out <= b_in;
      acc   <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/matrix_multiplier.sv
// Output-stationary MxN systolic array computing C = A x B with skewed edge injection.
// Build option: MATMUL_SIGNED_EN (two's-complement operands and results).
//
// state | meaning
// IDLE  | waiting for start; operands captured and array cleared on start
// RUN   | stepping t through injections, then loading c_flat and pulsing done
module matrix_multiplier
  import matmul_pkg::*;
#(
  parameter int M  = 4,
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [M*K*DW-1:0] a_flat,
  input  logic [K*N*DW-1:0] b_flat,
  output logic              busy,
  output logic              done,
  output logic [M*N*AW-1:0] c_flat
);

  localparam int LAT = lat(M, N, K);
  localparam int TW  = $clog2(LAT + 1);

  state_t            state;
  logic [TW-1:0]     t;
  logic [M*K*DW-1:0] a_reg;
  logic [K*N*DW-1:0] b_reg;
  logic              clr;
  logic              en;

  logic [DW-1:0] a_edge [M];
  logic [DW-1:0] b_edge [N];
  logic [DW-1:0] a_w    [M][N];
  logic [DW-1:0] b_w    [M][N];
  logic [AW-1:0] acc_w  [M][N];

  assign clr = (state == IDLE) && start;
  // The final RUN cycle only transfers accumulators, so no MAC happens there.
  assign en  = (state == RUN) && (int'(t) <= M + N + K - 3);

  always_comb begin
    for (int i = 0; i < M; i++) begin
      a_edge[i] = '0;
      for (int k = 0; k < K; k++)
        if (int'(t) == i + k) a_edge[i] = a_reg[(i*K+k)*DW +: DW];
    end
    for (int j = 0; j < N; j++) begin
      b_edge[j] = '0;
      for (int k = 0; k < K; k++)
        if (int'(t) == j + k) b_edge[j] = b_reg[(k*N+j)*DW +: DW];
    end
  end

  for (genvar i = 0; i < M; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in;
      logic [DW-1:0] b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_int
        assign a_in = a_w[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_int
        assign b_in = b_w[i-1][j];
      end
      matmul_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .a_in  (a_in),
        .b_in  (b_in),
        .a_out (a_w[i][j]),
        .b_out (b_w[i][j]),
        .acc   (acc_w[i][j])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      c_flat <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_flat;
            b_reg <= b_flat;
            t     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (int'(t) == LAT - 1) begin
            for (int i = 0; i < M; i++)
              for (int j = 0; j < N; j++)
                c_flat[(i*N+j)*AW +: AW] <= acc_w[i][j];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            t <= t + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// Directed and randomized bench for matrix_multiplier against a plain-arithmetic matrix product model.
module tb_matrix_multiplier;

  localparam int M = 4, N = 4, K = 4, DW = 16, AW = 32, LAT = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [M*K*DW-1:0] a_flat = '0;
  logic [K*N*DW-1:0] b_flat = '0;
  logic              busy;
  logic              done;
  logic [M*N*AW-1:0] c_flat;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] am [M][K];
  logic [DW-1:0] bm [K][N];
  logic [AW-1:0] exp_c [M][N];

  matrix_multiplier #(.M(M), .N(N), .K(K), .DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_flat (a_flat),
    .b_flat (b_flat),
    .busy   (busy),
    .done   (done),
    .c_flat (c_flat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [AW-1:0] cval(input int i, input int j);
    return c_flat[(i*N+j)*AW +: AW];
  endfunction

  task automatic pack_ops();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) a_flat[(i*K+k)*DW +: DW] = am[i][k];
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) b_flat[(k*N+j)*DW +: DW] = bm[k][j];
  endtask

  task automatic rand_ops();
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) am[i][k] = DW'($urandom);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) bm[k][j] = DW'($urandom);
    pack_ops();
  endtask

  task automatic fill_ops(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) am[i][k] = av;
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) bm[k][j] = bv;
    pack_ops();
  endtask

  // Reference C = A x B, wrapped to AW bits.
  task automatic snapshot();
    longint s;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < K; k++) begin
`ifdef MATMUL_SIGNED_EN
          s += longint'($signed(am[i][k])) * longint'($signed(bm[k][j]));
`else
          s += longint'(am[i][k]) * longint'(bm[k][j]);
`endif
        end
        exp_c[i][j] = s[AW-1:0];
      end
  endtask

  // mode 0: plain run; 1: new operands plus start pulse mid-run; 2: new operands only mid-run
  task automatic run(input string tag, input int mode);
    int lat_seen, busy_cnt, extra;
    snapshot();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    lat_seen = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc == 3 && mode != 0) begin
        rand_ops();
        if (mode == 1) start = 1'b1;
      end
      if (cyc == 4) start = 1'b0;
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      if (done) begin
        lat_seen = cyc;
        break;
      end
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat_seen), 64'(LAT));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT));
    chk({tag, "_busy_after_done"}, 64'(busy), 64'd0);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("%s_c%0d%0d", tag, i, j), 64'(cval(i, j)), 64'(exp_c[i][j]));
    extra = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk({tag, "_extra_done"}, 64'(extra), 64'd0);
    chk({tag, "_c_hold"}, 64'(cval(M-1, N-1)), 64'(exp_c[M-1][N-1]));
  endtask

  initial begin
    int extra;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_c", 64'(c_flat == '0), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    rst = 1'b0;

    // Identity: A = 1..16 row-major, B = I
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) am[i][k] = DW'(i*K + k + 1);
    for (int k = 0; k < K; k++)
      for (int j = 0; j < N; j++) bm[k][j] = (k == j) ? DW'(1) : DW'(0);
    pack_ops();
    run("ident", 0);
    chk("ident_c00", 64'(cval(0, 0)), 64'd1);
    chk("ident_c11", 64'(cval(1, 1)), 64'd6);
    chk("ident_c22", 64'(cval(2, 2)), 64'd11);
    chk("ident_c33", 64'(cval(3, 3)), 64'd16);
    chk("ident_c01", 64'(cval(0, 1)), 64'd2);
    chk("ident_c30", 64'(cval(3, 0)), 64'd13);

    fill_ops(16'h0001, 16'h0001);
    run("ones", 0);
    chk("ones_c12", 64'(cval(1, 2)), 64'd4);

    fill_ops(16'hFFFF, 16'hFFFF);
    run("maxval", 0);
`ifdef MATMUL_SIGNED_EN
    chk("maxval_c21", 64'(cval(2, 1)), 64'd4);
`else
    chk("maxval_c21", 64'(cval(2, 1)), 64'hFFF80004);
`endif

    rand_ops();
    run("midstart", 1);
    rand_ops();
    run("midchange", 2);

    // Reset five cycles into a run
    rand_ops();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_c", 64'(c_flat == '0), 64'd1);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_done", 64'(done), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    extra = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("rst_mid_no_done", 64'(extra), 64'd0);

    rand_ops();
    run("after_rst", 0);
    for (int r = 0; r < 3; r++) begin
      rand_ops();
      run($sformatf("rand%0d", r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
